imem_dmem_arbiter: RTL
======================

// Module: imem_dmem_arbiter
// PURPOSE
//  Shares one single-port 32-bit MEM between the fetch stage (I port, read-only)
//  and the memory stage (D port, load/store) of the 5-stage pipeline.
//  Grants at most one access per cycle. Read data returns one cycle later, tagged to its owner.
//  The pipeline stalls IF on !i_gnt and MM on !d_gnt.
//  A starvation guard limits how long D can lock out instruction fetch.
// PARAMETERS
//  AW          12  word-address width (MEM WORD=4096)
//  DW          32  data width
//  STARVE_MAX  4   max consecutive D grants while i_req is pending before I is forced; range 1..15
// PORTS
//  clk       in   1   clock, all state on rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  i_req     in   1   fetch read request, held until granted
//  i_addr    in   AW  fetch word address
//  i_gnt     out  1   fetch granted this cycle (combinational)
//  i_rvalid  out  1   i_rdata valid (registered, 1 cycle after i_gnt)
//  i_rdata   out  DW  fetch read data (= m_rdata)
//  d_req     in   1   data request, held until granted
//  d_we      in   1   1=store, 0=load
//  d_addr    in   AW  data word address
//  d_wdata   in   DW  store data
//  d_gnt     out  1   data granted this cycle (combinational)
//  d_rvalid  out  1   d_rdata valid (registered, 1 cycle after a load grant)
//  d_rdata   out  DW  load data (= m_rdata)
//  m_en      out  1   MEM access strobe (= i_gnt|d_gnt)
//  m_we      out  1   MEM write enable (= d_gnt&d_we)
//  m_addr    out  AW  MEM address, muxed from the granted port, 0 when idle
//  m_wdata   out  DW  MEM write data (= d_wdata)
//  m_rdata   in   DW  MEM read data, valid 1 cycle after m_en&!m_we
//  stat_conf out  32  cycles with i_req&d_req (stats build only)
//  stat_istl out  32  cycles with i_req&!i_gnt (stats build only)
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=PRI_D, streak=0, i_rvalid=d_rvalid=0, stats=0.
//  Any read in flight at reset is dropped; no rvalid for it after release.
//  Outputs are combinational from req and state, so gnt is 0 while rst_n=0.
//  FSM PRI_D (default):
//   - d_req -> grant D; else i_req -> grant I.
//   - streak is 4 bits. It increments on each D grant while i_req=1.
//   - streak clears on any cycle with i_req=0 or with an I grant.
//   - D grant with i_req and streak==STARVE_MAX-1 -> go to PRI_I, streak<=0.
//  FSM PRI_I:
//   - i_req -> grant I, return to PRI_D.
//   - i_req dropped -> return to PRI_D with no grant unless d_req; d_req is then granted that cycle.
//   - d_req waits (d_gnt=0) while I is granted.
//  At most one of i_gnt/d_gnt is 1 in any cycle. A gnt never asserts without its req.
//  Read tag register owner in {NONE,I,D}:
//   - set to I on i_gnt, to D on d_gnt&!d_we, else NONE.
//   - i_rvalid=(owner==I), d_rvalid=(owner==D).
//  A store grant produces no rvalid; load-after-store to the same addr returns the new data.
//  Back-to-back grants are allowed every cycle; throughput 1 access/cycle.
//  Address and data are never latched; requesters hold addr/wdata stable until granted.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   - stat_conf and stat_istl are 32-bit counters, wrap at 2^32-1 -> 0, cleared by reset.
//  ARB_STATS_EN undefined:
//   - both ports are present and tied to 0, no counter flops.
//   - Grant and data behaviour is identical in both builds.
// TESTING
//  - i_req=1 only, addrs 0,1,2 over 3 cycles -> i_gnt=1 each cycle;
//    i_rvalid=1 cycles 2..4 with MEM[0..2]; d_rvalid stays 0.
//  - i_req=d_req=1 (load addr 5), STARVE_MAX=4, d_req held 6 cycles ->
//    grant pattern D,D,D,D,I,D,D; d_rvalid/i_rvalid follow 1 cycle later.
//  - store d_addr=7 wdata=0xDEADBEEF, then load addr 7 next cycle ->
//    m_we=1 then 0; d_rvalid=1 with 0xDEADBEEF; no rvalid after the store.
//  - i_gnt on addr 3, rst_n pulsed low for half a cycle before the next edge ->
//    i_rvalid=0 after release; FSM=PRI_D; stats=0.
//  - ARB_STATS_EN, 10 cycles of i_req=d_req=1 ->
//    stat_conf=10; stat_istl=8 with STARVE_MAX=4 (I granted cycles 5 and 10).
//  - i_req=0 in PRI_I (forced) with d_req=1 ->
//    d_gnt=1 that same cycle; FSM returns to PRI_D.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port 32-bit memory between instruction
// fetch (I, read-only) and the memory stage (D, load/store).
// - One grant per cycle, D preferred, with a starvation guard that forces an
//   I grant after STARVE_MAX consecutive D grants while I is waiting.
// - Read data returns one cycle after the grant, tagged to its owner.
// - Build option ARB_STATS_EN: enables the stat_conf / stat_istl counters.
//   Without it both ports read as 0 and no counter flops exist.
module imem_dmem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  // statistics
  output logic [31:0]   stat_conf,
  output logic [31:0]   stat_istl
);

  // arbitration states
  localparam logic ST_PRI_D = 1'b0;
  localparam logic ST_PRI_I = 1'b1;

  // read-return owner tags
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // streak value at which the next D grant hands priority to I
  localparam logic [3:0] STREAK_LAST = 4'(STARVE_MAX - 1);

  logic       state_q,  state_d;
  logic [3:0] streak_q, streak_d;
  logic [1:0] owner_q,  owner_d;

  // Grant decode: purely from requests and state; nothing granted in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == ST_PRI_I) begin
        // forced fetch slot; if fetch withdrew, D may still use the cycle
        if (i_req)      i_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
      end else begin
        if (d_req)      d_gnt = 1'b1;
        else if (i_req) i_gnt = 1'b1;
      end
    end
  end

  // Memory-side mux; address is 0 when idle, write data passes through.
  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_wdata = d_wdata;
    if (d_gnt)      m_addr = d_addr;
    else if (i_gnt) m_addr = i_addr;
    else            m_addr = '0;
  end

  // Starvation guard: count D grants that lock out a waiting fetch.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (!i_req || i_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt) begin
      if (streak_q == STREAK_LAST) begin
        state_d  = ST_PRI_I;
        streak_d = 4'd0;
      end else begin
        streak_d = streak_q + 4'd1;
      end
    end
    // PRI_I lasts exactly one cycle: either I is served or it has gone away
    if (state_q == ST_PRI_I) state_d = ST_PRI_D;
  end

  // Tag the read that is launched this cycle; stores return nothing.
  always_comb begin
    if (i_gnt)              owner_d = OWN_I;
    else if (d_gnt && !d_we) owner_d = OWN_D;
    else                    owner_d = OWN_NONE;
  end

  // Arbitration state and read tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PRI_D;
      streak_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

  // Read return: both ports see the memory data, the tag says whose it is.
  always_comb begin
    i_rvalid = (owner_q == OWN_I);
    d_rvalid = (owner_q == OWN_D);
    i_rdata  = m_rdata;
    d_rdata  = m_rdata;
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_conf_q, stat_istl_q;

  // Contention and fetch-stall counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conf_q <= 32'd0;
      stat_istl_q <= 32'd0;
    end else begin
      if (i_req && d_req)  stat_conf_q <= stat_conf_q + 32'd1;
      if (i_req && !i_gnt) stat_istl_q <= stat_istl_q + 32'd1;
    end
  end

  assign stat_conf = stat_conf_q;
  assign stat_istl = stat_istl_q;
`else
  assign stat_conf = 32'd0;
  assign stat_istl = 32'd0;
`endif

endmodule
